// File: rtl/m_adc_spi_ctrl.sv
// Periodic CNV/SCK front-end for the paired 24-bit current and voltage ADCs.
// Both SDO lines are shifted in parallel; completed frames are presented with a valid pulse.
//
// state   | meaning
// IDLE    | waiting for a period trigger
// CNV     | conversion pulse high for CNV_HIGH_CYC cycles
// WAIT    | conversion time, CNV low, before the first SCK
// SHIFT   | DATA_WIDTH SCK periods, both SDO lines captured on SCK rising
// DONE    | one cycle: raw outputs updated, o_data_valid high
module m_adc_spi_ctrl #(
    parameter int DATA_WIDTH    = 24,
    parameter int CLK_DIV       = 2,
    parameter int CNV_HIGH_CYC  = 4,
    parameter int CONV_WAIT_CYC = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [31:0]           i_cyc_t,
    input  logic                  i_i_sdo,
    input  logic                  i_v_sdo,
    output logic                  o_cnv,
    output logic                  o_sck,
    output logic [DATA_WIDTH-1:0] o_i_adc_raw_data,
    output logic [DATA_WIDTH-1:0] o_v_adc_raw_data,
    output logic                  o_data_valid,
    output logic                  o_busy,
    output logic                  o_overrun
);

    localparam int TMR_MAX = (CNV_HIGH_CYC > CONV_WAIT_CYC) ? CNV_HIGH_CYC : CONV_WAIT_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int DIV_W   = $clog2(CLK_DIV + 1);
    localparam int HALF_W  = $clog2(2 * DATA_WIDTH + 1);

    localparam logic [TMR_W-1:0]  CNV_LOAD  = TMR_W'(CNV_HIGH_CYC - 1);
    localparam logic [TMR_W-1:0]  WAIT_LOAD = TMR_W'(CONV_WAIT_CYC - 1);
    localparam logic [DIV_W-1:0]  DIV_LOAD  = DIV_W'(CLK_DIV - 1);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CNV   = 3'd1,
        S_WAIT  = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [31:0]           r_cnt;
    logic [31:0]           w_cyc_last;
    logic                  w_trig;

    logic [TMR_W-1:0]      r_tmr;
    logic [DIV_W-1:0]      r_div;
    logic [HALF_W-1:0]     r_half;
    logic [DATA_WIDTH-1:0] r_i_shift;
    logic [DATA_WIDTH-1:0] r_v_shift;
    logic [DATA_WIDTH-1:0] r_i_raw;
    logic [DATA_WIDTH-1:0] r_v_raw;

    logic                  r_cnv;
    logic                  r_sck;
    logic                  r_valid;
    logic                  r_busy;
    logic                  r_overrun;

    logic                  w_cnv_nxt;
    logic                  w_sck_nxt;
    logic                  w_valid_nxt;
    logic                  w_busy_nxt;
    logic                  w_overrun_nxt;
    logic                  w_shift_en;

    // Period counter: >= compare lets a shortened period take effect immediately.
    assign w_cyc_last = i_cyc_t - 32'd1;
    assign w_trig     = (i_cyc_t != 32'd0) && (r_cnt == 32'd0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= 32'd0;
        end else if (i_cyc_t == 32'd0) begin
            r_cnt <= 32'd0;
        end else if (r_cnt >= w_cyc_last) begin
            r_cnt <= 32'd0;
        end else begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_trig) begin
                    w_state_nxt = S_CNV;
                end
            end
            S_CNV: begin
                if (r_tmr == '0) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_tmr == '0) begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if ((r_div == '0) && (r_half == HALF_LAST)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output values for the next cycle; every output pin comes straight from a flop.
    always_comb begin
        w_cnv_nxt     = 1'b0;
        w_sck_nxt     = 1'b0;
        w_valid_nxt   = 1'b0;
        w_busy_nxt    = 1'b0;
        w_overrun_nxt = 1'b0;
        w_shift_en    = 1'b0;
        w_cnv_nxt     = (w_state_nxt == S_CNV);
        w_valid_nxt   = (w_state_nxt == S_DONE);
        w_busy_nxt    = (w_state_nxt != S_IDLE);
        w_overrun_nxt = w_trig && (r_state != S_IDLE);
        if (r_state == S_SHIFT) begin
            w_sck_nxt  = (r_div == '0) ? ~r_sck : r_sck;
            w_shift_en = (r_div == '0) && !r_sck;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnv     <= 1'b0;
            r_sck     <= 1'b0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_cnv     <= w_cnv_nxt;
            r_sck     <= w_sck_nxt;
            r_valid   <= w_valid_nxt;
            r_busy    <= w_busy_nxt;
            r_overrun <= w_overrun_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tmr     <= '0;
            r_div     <= '0;
            r_half    <= '0;
            r_i_shift <= '0;
            r_v_shift <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_trig) begin
                        r_tmr     <= CNV_LOAD;
                        r_i_shift <= '0;
                        r_v_shift <= '0;
                    end
                end
                S_CNV: begin
                    if (r_tmr == '0) begin
                        r_tmr <= WAIT_LOAD;
                    end else begin
                        r_tmr <= r_tmr - TMR_W'(1);
                    end
                end
                S_WAIT: begin
                    if (r_tmr != '0) begin
                        r_tmr <= r_tmr - TMR_W'(1);
                    end else begin
                        r_div  <= DIV_LOAD;
                        r_half <= '0;
                    end
                end
                S_SHIFT: begin
                    if (r_div == '0) begin
                        r_div  <= DIV_LOAD;
                        r_half <= r_half + HALF_W'(1);
                    end else begin
                        r_div <= r_div - DIV_W'(1);
                    end
                    if (w_shift_en) begin
                        r_i_shift <= {r_i_shift[DATA_WIDTH-2:0], i_i_sdo};
                        r_v_shift <= {r_v_shift[DATA_WIDTH-2:0], i_v_sdo};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Raw outputs only ever take a complete frame, in step with the valid pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_i_raw <= '0;
            r_v_raw <= '0;
        end else if (w_state_nxt == S_DONE) begin
            r_i_raw <= r_i_shift;
            r_v_raw <= r_v_shift;
        end
    end

    assign o_cnv            = r_cnv;
    assign o_sck            = r_sck;
    assign o_i_adc_raw_data = r_i_raw;
    assign o_v_adc_raw_data = r_v_raw;
    assign o_data_valid     = r_valid;
    assign o_busy           = r_busy;
    assign o_overrun        = r_overrun;

endmodule

// File: tb/tb_m_adc_spi_ctrl.sv
// Bench for m_adc_spi_ctrl: period/latency reference model feeding a scoreboard,
// SDO models replaying the frames the model expects, per-cycle CNV/SCK/busy checks.
module tb_m_adc_spi_ctrl;

    localparam int     DW = 24;
    localparam longint L  = 111;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   cyc_t = 32'd0;
    logic          i_sdo = 1'b0;
    logic          v_sdo = 1'b0;
    logic          o_cnv;
    logic          o_sck;
    logic [DW-1:0] o_i_raw;
    logic [DW-1:0] o_v_raw;
    logic          o_valid;
    logic          o_busy;
    logic          o_overrun;

    always #5 clk = ~clk;

    m_adc_spi_ctrl #(
        .DATA_WIDTH   (24),
        .CLK_DIV      (2),
        .CNV_HIGH_CYC (4),
        .CONV_WAIT_CYC(10)
    ) u_dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_cyc_t         (cyc_t),
        .i_i_sdo         (i_sdo),
        .i_v_sdo         (v_sdo),
        .o_cnv           (o_cnv),
        .o_sck           (o_sck),
        .o_i_adc_raw_data(o_i_raw),
        .o_v_adc_raw_data(o_v_raw),
        .o_data_valid    (o_valid),
        .o_busy          (o_busy),
        .o_overrun       (o_overrun)
    );

    typedef struct {
        longint        due;
        logic [DW-1:0] wi;
        logic [DW-1:0] wv;
    } exp_t;

    int            n_checks = 0;
    int            n_errors = 0;
    longint        cyc = 0;
    longint        cnt = 0;
    longint        acc = -1000;
    longint        idle_at = 0;
    bit            rst_q = 1'b1;
    bit            mon_en = 1'b0;
    exp_t          q[$];
    longint        oq[$];
    logic [47:0]   sdo_q[$];
    logic [47:0]   dq[$];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: period trigger rule, accept when idle, else overrun.
    always @(posedge clk) begin
        longint      k;
        logic [47:0] w;
        k = cyc;
        cyc = cyc + 1;
        rst_q = rst;
        if (rst) begin
            cnt = 0;
            acc = -1000;
            idle_at = 0;
            q.delete();
            oq.delete();
            sdo_q.delete();
        end else begin
            if (cyc_t != 0 && cnt == 0) begin
                if (k >= idle_at) begin
                    if (dq.size() > 0) w = dq.pop_front();
                    else w = {24'($urandom), 24'($urandom)};
                    q.push_back('{k + L, w[47:24], w[23:0]});
                    sdo_q.push_back(w);
                    acc = k;
                    idle_at = k + L + 1;
                end else begin
                    oq.push_back(k + 1);
                end
            end
            if (cyc_t == 0) cnt = 0;
            else if (cnt >= longint'(cyc_t) - 1) cnt = 0;
            else cnt = cnt + 1;
        end
    end

    // SDO models: new frame at CNV rising, next bit after every SCK rising edge.
    logic [47:0] fr = 48'h0;
    int          bitk = DW;
    logic        p_cnv = 1'b0;
    logic        p_sck = 1'b0;

    always @(negedge clk) begin
        if (o_cnv === 1'b1 && p_cnv === 1'b0) begin
            fr = (sdo_q.size() > 0) ? sdo_q.pop_front() : 48'h0;
            bitk = 0;
        end
        if (o_sck === 1'b1 && p_sck === 1'b0) bitk++;
        p_cnv = o_cnv;
        p_sck = o_sck;
        if (bitk < DW) begin
            i_sdo = fr[47-bitk];
            v_sdo = fr[23-bitk];
        end else begin
            {i_sdo, v_sdo} = 2'($urandom);
        end
    end

    // Monitor: per-cycle waveform expectations plus scoreboard pops.
    logic [DW-1:0] last_i = '0;
    logic [DW-1:0] last_v = '0;
    exp_t          e;

    always @(negedge clk) begin
        longint c;
        bit     exp_cnv, exp_busy, exp_sck;
        if (mon_en) begin
            c = cyc;
            exp_cnv  = (c >= acc + 1) && (c <= acc + 4);
            exp_busy = (c >= acc + 1) && (c <= acc + L);
            exp_sck  = (c >= acc + 15) && (c <= acc + 110) && (((c - acc - 15) % 4) >= 2);
            check("cnv", longint'(o_cnv), longint'(exp_cnv));
            check("busy", longint'(o_busy), longint'(exp_busy));
            check("sck", longint'(o_sck), longint'(exp_sck));
            if (rst_q) begin
                last_i = '0;
                last_v = '0;
            end
            if (q.size() > 0 && q[0].due == c) begin
                e = q.pop_front();
                check("valid_at_due", longint'(o_valid), 1);
                if (o_valid === 1'b1) begin
                    check("i_data", longint'(o_i_raw), longint'(e.wi));
                    check("v_data", longint'(o_v_raw), longint'(e.wv));
                    last_i = e.wi;
                    last_v = e.wv;
                end
            end else begin
                check("valid_unexpected", longint'(o_valid), 0);
            end
            check("i_hold", longint'(o_i_raw), longint'(last_i));
            check("v_hold", longint'(o_v_raw), longint'(last_v));
            if (oq.size() > 0 && oq[0] == c) begin
                void'(oq.pop_front());
                check("overrun_at_due", longint'(o_overrun), 1);
            end else begin
                check("overrun_unexpected", longint'(o_overrun), 0);
            end
        end
    end

    initial begin
        longint c0;
        rst = 1'b1;
        cyc_t = 32'd0;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        check("rst_cnv", longint'(o_cnv), 0);
        check("rst_sck", longint'(o_sck), 0);
        check("rst_busy", longint'(o_busy), 0);
        check("rst_valid", longint'(o_valid), 0);
        check("rst_overrun", longint'(o_overrun), 0);
        check("rst_i_raw", longint'(o_i_raw), 0);
        check("rst_v_raw", longint'(o_v_raw), 0);
        rst = 1'b0;

        // Disabled period: nothing may move.
        repeat (1000) @(negedge clk);

        // Fixed pattern, period comfortably above latency.
        repeat (3) dq.push_back({24'hA5C3F0, 24'h123456});
        cyc_t = 32'd200;
        repeat (650) @(negedge clk);

        // Period shorter than latency: every other trigger dropped.
        cyc_t = 32'd100;
        repeat (700) @(negedge clk);

        // Reset in the middle of the shift phase.
        cyc_t = 32'd200;
        for (int t = 0; t < 1000; t++) begin
            @(negedge clk);
            if (o_busy === 1'b1 && bitk == 10) break;
        end
        check("rst_mid_bit", longint'(bitk), 10);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_sck", longint'(o_sck), 0);
        check("mid_rst_cnv", longint'(o_cnv), 0);
        check("mid_rst_busy", longint'(o_busy), 0);
        check("mid_rst_valid", longint'(o_valid), 0);
        check("mid_rst_i_raw", longint'(o_i_raw), 0);
        check("mid_rst_v_raw", longint'(o_v_raw), 0);
        rst = 1'b0;
        repeat (500) @(negedge clk);

        // Shorten the period while the counter is past the new limit.
        cyc_t = 32'd1000;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            if (cnt == 500) break;
        end
        c0 = cyc;
        cyc_t = 32'd300;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (o_cnv === 1'b1) break;
        end
        check("period_cut_trigger", cyc, c0 + 2);
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (o_cnv === 1'b0) break;
        end
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (o_cnv === 1'b1) break;
        end
        check("period_cut_next", cyc, c0 + 302);
        repeat (300) @(negedge clk);

        // Extreme and edge-bit patterns back to back.
        dq.push_back({24'hFFFFFF, 24'h000000});
        dq.push_back({24'h800001, 24'h7FFFFE});
        repeat (700) @(negedge clk);

        cyc_t = 32'd0;
        repeat (300) @(negedge clk);
        check("frames_outstanding", longint'(q.size()), 0);
        check("overruns_outstanding", longint'(oq.size()), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
